// File: rtl/tx_scheduler.sv
// Transmit scheduler: multiplexes user beats, idle and periodic clock-compensation bursts onto one lane.
// Define TX_SCHEDULER_CC_INSERT_EN to build the CC timer, request flag, burst counter and CC state.
module tx_scheduler #(
  parameter int DATA_W    = 16,
  parameter int CC_PERIOD = 5000,
  parameter int CC_LEN    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              channel_up,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              send_data,
  output logic [DATA_W-1:0] data_out,
  output logic              send_idle,
  output logic              send_cc
);

  // Empty marker scope that shows up in the elaborated hierarchy when CC parameters are out of range.
  if (CC_PERIOD < CC_LEN + 2 || CC_LEN < 1) begin : g_illegal_cc_params
  end

`ifdef TX_SCHEDULER_CC_INSERT_EN
  typedef enum logic [1:0] {DOWN, RUN, CC} state_t;

  localparam int TIMER_W = (CC_PERIOD > 2) ? $clog2(CC_PERIOD) : 1;
  localparam int BURST_W = (CC_LEN > 1) ? $clog2(CC_LEN) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CC_PERIOD - 1);
  localparam logic [BURST_W-1:0] BURST_LOAD = BURST_W'(CC_LEN - 1);

  state_t             state_reg;
  logic               cc_req_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic [BURST_W-1:0] burst_reg;
  logic               timer_hit;

  assign timer_hit = (state_reg != DOWN) && (timer_reg == TIMER_LAST);
  assign tx_ready  = channel_up && (state_reg == RUN) && !cc_req_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= DOWN;
      cc_req_reg <= 1'b0;
      timer_reg  <= '0;
      burst_reg  <= '0;
      send_data  <= 1'b0;
      send_idle  <= 1'b0;
      send_cc    <= 1'b0;
      data_out   <= '0;
    end else if (!channel_up) begin
      state_reg  <= DOWN;
      cc_req_reg <= 1'b0;
      timer_reg  <= '0;
      burst_reg  <= '0;
      send_data  <= 1'b0;
      send_idle  <= 1'b1;
      send_cc    <= 1'b0;
    end else begin
      send_data <= 1'b0;
      send_idle <= 1'b0;
      send_cc   <= 1'b0;
      // Timer runs free through RUN and CC so the CC cadence is independent of traffic.
      if (state_reg != DOWN) begin
        timer_reg <= timer_hit ? '0 : timer_reg + 1'b1;
        if (timer_hit)
          cc_req_reg <= 1'b1;
      end
      case (state_reg)
        DOWN: begin
          state_reg <= RUN;
          send_idle <= 1'b1;
        end
        RUN: begin
          if (cc_req_reg) begin
            state_reg  <= CC;
            send_cc    <= 1'b1;
            burst_reg  <= BURST_LOAD;
            cc_req_reg <= timer_hit;
          end else if (tx_valid) begin
            send_data <= 1'b1;
            data_out  <= tx_data;
          end else begin
            send_idle <= 1'b1;
          end
        end
        CC: begin
          if (burst_reg != '0) begin
            send_cc   <= 1'b1;
            burst_reg <= burst_reg - 1'b1;
          end else begin
            state_reg <= RUN;
            send_idle <= 1'b1;
          end
        end
        default: begin
          state_reg <= DOWN;
          send_idle <= 1'b1;
        end
      endcase
    end
  end
`else
  typedef enum logic {DOWN, RUN} state_t;

  state_t state_reg;

  assign tx_ready = channel_up && (state_reg == RUN);
  assign send_cc  = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= DOWN;
      send_data <= 1'b0;
      send_idle <= 1'b0;
      data_out  <= '0;
    end else if (!channel_up) begin
      state_reg <= DOWN;
      send_data <= 1'b0;
      send_idle <= 1'b1;
    end else begin
      send_data <= 1'b0;
      send_idle <= 1'b0;
      case (state_reg)
        DOWN: begin
          state_reg <= RUN;
          send_idle <= 1'b1;
        end
        RUN: begin
          if (tx_valid) begin
            send_data <= 1'b1;
            data_out  <= tx_data;
          end else begin
            send_idle <= 1'b1;
          end
        end
        default: begin
          state_reg <= DOWN;
          send_idle <= 1'b1;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_tx_scheduler.sv
// Bench for tx_scheduler: directed and random traffic checked against a cycle-age model of the lane schedule.
module tb_tx_scheduler;
  localparam int DATA_W    = 16;
  localparam int CC_PERIOD = 16;
  localparam int CC_LEN    = 4;
`ifdef TX_SCHEDULER_CC_INSERT_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              channel_up;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              send_data;
  logic [DATA_W-1:0] data_out;
  logic              send_idle;
  logic              send_cc;

  tx_scheduler #(.DATA_W(DATA_W), .CC_PERIOD(CC_PERIOD), .CC_LEN(CC_LEN)) dut (
    .clk(clk), .rst(rst), .channel_up(channel_up), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .send_data(send_data), .data_out(data_out),
    .send_idle(send_idle), .send_cc(send_cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_accept = 0;
  int n_sent   = 0;

  // Model state: cycles spent since entering RUN (-1 while down), plus expected registered outputs.
  int                age = -1;
  logic              exp_sd = 1'b0;
  logic              exp_si = 1'b0;
  logic              exp_sc = 1'b0;
  logic [DATA_W-1:0] exp_data = '0;
  logic [DATA_W-1:0] word = 16'h0001;

  // A CC request appears every CC_PERIOD cycles after the first; it and the CC_LEN CC cycles block traffic.
  function automatic bit in_burst(int a);
    return CC_EN && (a >= CC_PERIOD) && ((a % CC_PERIOD) <= CC_LEN);
  endfunction

  function automatic bit model_ready(int a, logic cu);
    return cu && (a >= 0) && !in_burst(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("send_data", 32'(send_data), 32'(exp_sd));
    check("send_idle", 32'(send_idle), 32'(exp_si));
    check("send_cc",   32'(send_cc),   32'(exp_sc));
    check("data_out",  32'(data_out),  32'(exp_data));
  endtask

  task automatic model_reset();
    age      = -1;
    exp_sd   = 1'b0;
    exp_si   = 1'b0;
    exp_sc   = 1'b0;
    exp_data = '0;
  endtask

  task automatic cycle(input logic cu, input logic v, input logic [DATA_W-1:0] d, output bit acc);
    channel_up = cu;
    tx_valid   = v;
    tx_data    = d;
    #1;
    check("tx_ready", 32'(tx_ready), 32'(model_ready(age, cu)));
    acc    = v && model_ready(age, cu);
    exp_sd = 1'b0;
    exp_si = 1'b0;
    exp_sc = 1'b0;
    if (!cu || age < 0)
      exp_si = 1'b1;
    else if (in_burst(age)) begin
      if ((age % CC_PERIOD) < CC_LEN) exp_sc = 1'b1;
      else exp_si = 1'b1;
    end else if (acc) begin
      exp_sd   = 1'b1;
      exp_data = d;
    end else
      exp_si = 1'b1;
    age = cu ? age + 1 : -1;
    if (acc) n_accept++;
    @(posedge clk);
    #1;
    check_outputs();
    if (send_data === 1'b1) n_sent++;
    $display("cycle t=%0t cu=%0b v=%0b d=%04h acc=%0b -> sd=%0b si=%0b sc=%0b q=%04h", $time, cu, v, d, acc,
             send_data, send_idle, send_cc, data_out);
  endtask

  task automatic stream(input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b1, word, acc);
      if (acc) word = word + 1'b1;
    end
  endtask

  // Streams until the model reaches the given CC cycle index; reports whether it got there.
  task automatic stream_to_cc(input int idx, output bit found);
    bit acc;
    found = 1'b0;
    for (int i = 0; i < 3 * CC_PERIOD; i++) begin
      if (age >= CC_PERIOD && (age % CC_PERIOD) == idx) begin
        found = 1'b1;
        break;
      end
      cycle(1'b1, 1'b1, word, acc);
      if (acc) word = word + 1'b1;
    end
  endtask

  initial begin
    bit acc;
    bit found;
    logic [DATA_W-1:0] rdata;
    bit pending;

    rst        = 1'b1;
    channel_up = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_outputs();
      check("tx_ready_rst", 32'(tx_ready), 32'd0);
    end
    #4;
    rst = 1'b0;
    #1;
    check_outputs();

    // Channel down: idle from the first edge, never ready.
    repeat (3) cycle(1'b0, 1'b1, 16'hdead, acc);

    // Three directed beats, each held until taken, then traffic stops.
    for (int k = 1; k <= 3; k++) begin
      found = 1'b0;
      for (int t = 0; t < 4 && !found; t++) begin
        cycle(1'b1, 1'b1, 16'(k), acc);
        found = acc;
      end
      check("beat_taken", 32'(found), 32'd1);
    end
    repeat (3) cycle(1'b1, 1'b0, 16'h0000, acc);

    // Continuous streaming across several CC periods.
    stream(4 * CC_PERIOD);

`ifdef TX_SCHEDULER_CC_INSERT_EN
    // Channel drop during the second CC cycle, then recovery and a fresh CC cadence.
    stream_to_cc(2, found);
    check("reach_cc2", 32'(found), 32'd1);
    cycle(1'b0, 1'b1, word, acc);
    repeat (2) cycle(1'b0, 1'b1, word, acc);
    stream(3 * CC_PERIOD);
`endif

    // Random traffic with occasional channel drops; payload held until accepted.
    pending = 1'b0;
    rdata   = '0;
    for (int i = 0; i < 300; i++) begin
      logic cu;
      logic v;
      cu = ($urandom_range(0, 24) != 0);
      if (!pending) begin
        v     = ($urandom_range(0, 3) != 0);
        rdata = 16'($urandom);
      end else
        v = 1'b1;
      cycle(cu, v, rdata, acc);
      pending = v && !acc && ($urandom_range(0, 1) == 1);
    end

`ifdef TX_SCHEDULER_CC_INSERT_EN
    // Reset asserted in the middle of a CC burst clears outputs without a clock edge.
    stream_to_cc(2, found);
    check("reach_cc2_rst", 32'(found), 32'd1);
`else
    stream(CC_PERIOD + 3);
`endif
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check("tx_ready_async", 32'(tx_ready), 32'd0);
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    #1;
    check_outputs();
    stream(2 * CC_PERIOD + 4);

    check("beats_conserved", 32'(n_sent), 32'(n_accept));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 16: user data beat width.
REQ-002 SHALL have parameter CC_PERIOD, default 5000: cycles between clock-compensation (CC) burst requests; legal range ≥ CC_LEN+2.
REQ-003 SHALL have parameter CC_LEN, default 6: length of a CC burst in cycles; legal range ≥ 1.
REQ-004 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port channel_up  in  1  lane/channel ready; low means init/down.
REQ-007 SHALL have port tx_valid  in  1  user beat offered.
REQ-008 SHALL have port tx_data  in  DATA_W  user beat payload.
REQ-009 SHALL have port tx_ready  out  1  beat accepted when tx_valid & tx_ready.
REQ-010 SHALL have port send_data  out  1  data_out carries a user beat this cycle.
REQ-011 SHALL have port data_out  out  DATA_W  registered payload.
REQ-012 SHALL have port send_idle  out  1  drives the idle generator's send_idle input.
REQ-013 SHALL have port send_cc  out  1  emit CC symbol this cycle.

Function
REQ-014 SHALL implement states DOWN, RUN and CC; all outputs except tx_ready SHALL be registered.
REQ-015 SHALL make send_data, send_idle and send_cc one-hot after the first post-reset clock edge; all three SHALL be low only in reset.
REQ-016 DOWN: SHALL register send_idle=1; go to RUN on the edge where channel_up=1.
REQ-017 Any state, channel_up=0 at an edge: SHALL go to DOWN, register send_idle=1, clear cc_req, clear CC timer and burst counter; takes priority over all other transitions.
REQ-018 SHALL drive tx_ready = channel_up & (state==RUN) & !cc_req, combinationally.
REQ-019 RUN, no cc_req: on accept, SHALL register send_data=1 and data_out=tx_data (latency 1 cycle); otherwise register send_idle=1 and hold data_out.
REQ-020 CC timer SHALL count 0..CC_PERIOD-1 and wrap while in RUN or CC; when it equals CC_PERIOD-1, cc_req SHALL be set at that edge.
REQ-021 RUN with cc_req=1: SHALL go to CC, register send_cc=1, load burst counter with CC_LEN-1, clear cc_req.
REQ-022 CC with burst≠0: SHALL register send_cc=1 and decrement; with burst=0: go to RUN and register send_idle=1, so send_cc stays high exactly CC_LEN consecutive cycles.
REQ-023 No user beat SHALL be accepted from the cycle cc_req is high through the last CC cycle; tx_valid held across a burst SHALL be accepted on the first RUN cycle after it, with no loss or duplication.
REQ-024 If cc_req is set while in CC, which is illegal by REQ-002, it SHALL be held and serviced on return to RUN.

Reset
REQ-025 On rst=1 SHALL immediately set state=DOWN, send_data=send_idle=send_cc=0, data_out=0, cc_req=0, timer=0, burst=0; tx_ready=0.
REQ-026 SHALL abort any CC burst or data beat in progress on reset, with no residual output after release.

Configuration
REQ-027 Macro TX_SCHEDULER_CC_INSERT_EN defined: CC timer, cc_req, burst counter and state CC SHALL be present as specified.
REQ-028 Macro undefined: SHALL omit CC logic, tie send_cc=0, treat cc_req as 0; tx_ready = channel_up & (state==RUN); all other behaviour unchanged.

Verification (CC_PERIOD=16, CC_LEN=4, DATA_W=16, macro defined unless stated)
REQ-029 rst high, channel_up=0, release reset -> all outputs 0 during reset; send_idle=1 from first edge; tx_ready=0.
REQ-030 channel_up=1, tx_valid=1 with data 0x0001,0x0002,0x0003 -> tx_ready=1; send_data=1 with data_out 0x0001..0x0003 one cycle after each accept; send_idle=1 after tx_valid drops.
REQ-031 Continuous tx_valid from channel_up -> cc_req is set at the edge where the timer reaches 15, and tx_ready drops for that cycle; send_cc=1 for exactly 4 cycles, then 1 send_idle cycle; streaming resumes with no beat lost; repeats every 16 cycles.
REQ-032 Drop channel_up during the 2nd CC cycle -> next edge send_idle=1, send_cc=0, tx_ready=0; reassert -> timer restarts at 0 and the first CC follows 16 cycles later.
REQ-033 Assert rst mid-burst -> outputs 0 asynchronously, without waiting for a clock edge.
REQ-034 Macro undefined, 40 cycles streaming -> send_cc never 1, tx_ready never deasserts.
